// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the time-keeping side (master) and the digit scan scheduler (slave).
interface seg_scan_ctrl_if;
   logic        en;
   logic        load;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        lzb;
   logic [3:0]  bcd;
   logic        seg_blank;
   logic [3:0]  an_n;
   logic        dp_n;
   logic        frame_done;
   logic        upd_pending;

   modport master (
      output en, load, digits, dp_mask, lzb,
      input  bcd, seg_blank, an_n, dp_n, frame_done, upd_pending
   );

   modport slave (
      input  en, load, digits, dp_mask, lzb,
      output bcd, seg_blank, an_n, dp_n, frame_done, upd_pending
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit display scan scheduler sharing one BCD-to-7-segment decoder.
// Each slot starts with an anode-off guard, then shows one digit. Digit data is
// double-buffered: loads land in staging and commit to the displayed shadow only
// at the end of a frame (or immediately while scanning is disabled).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_GUARD | all anodes off, decoder blanked; first BLANK_CYCLES of a slot
//   ST_SHOW  | anode idx on, bcd = shadow digit idx; rest of the slot
module seg_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input logic          clk,
   input logic          rst,
   seg_scan_ctrl_if.slave bus
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GUARD_END = CW'(BLANK_CYCLES - 1);

   typedef enum logic {ST_GUARD, ST_SHOW} state_t;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [15:0]   stg_dig_q, stg_dig_d;
   logic [3:0]    stg_dp_q, stg_dp_d;
   logic          stg_lzb_q, stg_lzb_d;
   logic [15:0]   shd_dig_q, shd_dig_d;
   logic [3:0]    shd_dp_q, shd_dp_d;
   logic          shd_lzb_q, shd_lzb_d;
   logic          pend_q, pend_d;
   logic          fdone_q, fdone_d;

   logic [3:0]    an_n_q, an_n_d;
   logic [3:0]    bcd_q, bcd_d;
   logic          blank_q, blank_d;
   logic          dp_n_q, dp_n_d;

   logic          commit_pt;
   logic [3:0]    dig_sel;
   logic [3:0]    dig_zero;
   logic          lz_blank;

   // Next-state: slot timing, buffer commit and output decode from the next state,
   // so registered outputs line up with the state they describe.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      stg_dig_d = stg_dig_q;
      stg_dp_d  = stg_dp_q;
      stg_lzb_d = stg_lzb_q;
      shd_dig_d = shd_dig_q;
      shd_dp_d  = shd_dp_q;
      shd_lzb_d = shd_lzb_q;
      pend_d    = pend_q;
      fdone_d   = 1'b0;

      commit_pt = bus.en && (state_q == ST_SHOW) && (idx_q == 2'd3) && (cnt_q == CNT_LAST);

      if (!bus.en) begin
         state_d = ST_GUARD;
         idx_d   = 2'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_GUARD: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == GUARD_END) state_d = ST_SHOW;
            end
            default: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_GUARD;
                  idx_d   = idx_q + 2'd1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         endcase
      end

      // A disabled display has nothing to tear, so pending data commits at once
      // (and silently); otherwise only at the frame boundary.
      if ((commit_pt || !bus.en) && pend_q) begin
         shd_dig_d = stg_dig_q;
         shd_dp_d  = stg_dp_q;
         shd_lzb_d = stg_lzb_q;
         pend_d    = 1'b0;
         fdone_d   = commit_pt;
      end

      // Load after commit so a coincident load refills staging and keeps pending set.
      if (bus.load) begin
         stg_dig_d = bus.digits;
         stg_dp_d  = bus.dp_mask;
         stg_lzb_d = bus.lzb;
         pend_d    = 1'b1;
      end

      case (idx_d)
         2'd0:    dig_sel = shd_dig_d[3:0];
         2'd1:    dig_sel = shd_dig_d[7:4];
         2'd2:    dig_sel = shd_dig_d[11:8];
         default: dig_sel = shd_dig_d[15:12];
      endcase

      dig_zero = {shd_dig_d[15:12] == 4'd0, shd_dig_d[11:8] == 4'd0,
                  shd_dig_d[7:4] == 4'd0,   shd_dig_d[3:0] == 4'd0};

      // Digit 0 is never leading-zero blanked so an all-zero value still shows "0".
      case (idx_d)
         2'd1:    lz_blank = dig_zero[3] & dig_zero[2] & dig_zero[1];
         2'd2:    lz_blank = dig_zero[3] & dig_zero[2];
         2'd3:    lz_blank = dig_zero[3];
         default: lz_blank = 1'b0;
      endcase
      lz_blank = lz_blank & shd_lzb_d;

      bcd_d = dig_sel;
      if (state_d == ST_SHOW) begin
         an_n_d  = ~(4'b0001 << idx_d);
         blank_d = (dig_sel > 4'd9) | lz_blank;
         dp_n_d  = ~shd_dp_d[idx_d];
      end else begin
         an_n_d  = 4'b1111;
         blank_d = 1'b1;
         dp_n_d  = 1'b1;
      end
   end

   // State, buffers and registered outputs; reset aborts the frame and drops staged data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_GUARD;
         idx_q     <= 2'd0;
         cnt_q     <= '0;
         stg_dig_q <= 16'h0000;
         stg_dp_q  <= 4'h0;
         stg_lzb_q <= 1'b0;
         shd_dig_q <= 16'h0000;
         shd_dp_q  <= 4'h0;
         shd_lzb_q <= 1'b0;
         pend_q    <= 1'b0;
         fdone_q   <= 1'b0;
         an_n_q    <= 4'b1111;
         bcd_q     <= 4'h0;
         blank_q   <= 1'b1;
         dp_n_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         stg_dig_q <= stg_dig_d;
         stg_dp_q  <= stg_dp_d;
         stg_lzb_q <= stg_lzb_d;
         shd_dig_q <= shd_dig_d;
         shd_dp_q  <= shd_dp_d;
         shd_lzb_q <= shd_lzb_d;
         pend_q    <= pend_d;
         fdone_q   <= fdone_d;
         an_n_q    <= an_n_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
         dp_n_q    <= dp_n_d;
      end
   end

   assign bus.an_n        = an_n_q;
   assign bus.bcd         = bcd_q;
   assign bus.seg_blank   = blank_q;
   assign bus.dp_n        = dp_n_q;
   assign bus.frame_done  = fdone_q;
   assign bus.upd_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with an 8-cycle slot and 2-cycle guard.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg_scan_ctrl;

   localparam int SD = 8;
   localparam int BC = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seg_scan_ctrl_if bus_if ();

   seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic        lzb;
      logic [15:0] e_bcd;
      logic [3:0]  e_blank;
      logic [3:0]  e_dpn;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
      bus_if.load    = 1'b1;
      bus_if.digits  = d;
      bus_if.dp_mask = dp;
      bus_if.lzb     = lz;
   endtask

   // Returns on the falling edge where frame_done is high (cycle 0 of the new frame).
   task automatic wait_frame_done(input string name);
      int n;
      n = 0;
      while (bus_if.frame_done !== 1'b1 && n < 80) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus_if.frame_done !== 1'b1) begin
         failures++;
         $display("FAIL %s: frame_done timeout after %0d cycles, expected a pulse", name, n);
      end
   endtask

   // Called at cycle 0 of a frame; samples mid-SHOW of each digit, returns at cycle 28.
   task automatic check_frame(input string name, input logic [15:0] e_bcd,
                              input logic [3:0] e_blank, input logic [3:0] e_dpn);
      int cyc;
      logic [3:0] exp_an;
      cyc = 0;
      for (int d = 0; d < 4; d++) begin
         while (cyc < d * SD + 4) begin
            @(negedge clk);
            cyc++;
         end
         exp_an = ~(4'b0001 << d);
         chk($sformatf("%s an_n d%0d", name, d), {12'h0, bus_if.an_n}, {12'h0, exp_an});
         chk($sformatf("%s bcd d%0d", name, d), {12'h0, bus_if.bcd}, {12'h0, e_bcd[d*4 +: 4]});
         chk($sformatf("%s seg_blank d%0d", name, d), {15'h0, bus_if.seg_blank}, {15'h0, e_blank[d]});
         chk($sformatf("%s dp_n d%0d", name, d), {15'h0, bus_if.dp_n}, {15'h0, e_dpn[d]});
         if (d == 0)
            chk($sformatf("%s frame_done pulse", name), {15'h0, bus_if.frame_done}, 16'h0);
      end
   endtask

   initial begin
      logic [3:0] exp_an;

      vecs[0] = '{16'h1234, 4'b0100, 1'b0, 16'h1234, 4'b0000, 4'b1011};
      vecs[1] = '{16'h0700, 4'b0000, 1'b1, 16'h0700, 4'b1000, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b1110, 4'b1111};
      vecs[3] = '{16'h00B0, 4'b1001, 1'b0, 16'h00B0, 4'b0010, 4'b0110};
      vecs[4] = '{16'h0B00, 4'b0000, 1'b1, 16'h0B00, 4'b1100, 4'b1111};

      rst            = 1'b1;
      bus_if.en      = 1'b1;
      bus_if.load    = 1'b0;
      bus_if.digits  = 16'h0000;
      bus_if.dp_mask = 4'h0;
      bus_if.lzb     = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst an_n", {12'h0, bus_if.an_n}, 16'h000F);
      chk("rst bcd", {12'h0, bus_if.bcd}, 16'h0000);
      chk("rst seg_blank", {15'h0, bus_if.seg_blank}, 16'h0001);
      chk("rst dp_n", {15'h0, bus_if.dp_n}, 16'h0001);
      chk("rst frame_done", {15'h0, bus_if.frame_done}, 16'h0000);
      chk("rst upd_pending", {15'h0, bus_if.upd_pending}, 16'h0000);
      rst = 1'b0;

      // Free-running scan with empty shadow: cycle 0 is the reset GUARD of digit 0
      for (int i = 0; i < 40; i++) begin
         exp_an = ((i % SD) < BC) ? 4'b1111 : ~(4'b0001 << ((i / SD) % 4));
         chk($sformatf("scan an_n c%0d", i), {12'h0, bus_if.an_n}, {12'h0, exp_an});
         chk($sformatf("scan bcd c%0d", i), {12'h0, bus_if.bcd}, 16'h0000);
         chk($sformatf("scan dp_n c%0d", i), {15'h0, bus_if.dp_n}, 16'h0001);
         @(negedge clk);
      end

      // Table: load mid-frame, commit at frame end, inspect the following frame
      for (int v = 0; v < 5; v++) begin
         drive_load(vecs[v].digits, vecs[v].dp, vecs[v].lzb);
         @(negedge clk);
         bus_if.load = 1'b0;
         chk($sformatf("vec%0d upd_pending after load", v), {15'h0, bus_if.upd_pending}, 16'h0001);
         wait_frame_done($sformatf("vec%0d", v));
         chk($sformatf("vec%0d upd_pending at commit", v), {15'h0, bus_if.upd_pending}, 16'h0000);
         check_frame($sformatf("vec%0d", v), vecs[v].e_bcd, vecs[v].e_blank, vecs[v].e_dpn);
      end

      // Last-wins staging plus a load landing on the commit cycle (now at cycle 28)
      drive_load(16'h1111, 4'h0, 1'b0);
      @(negedge clk);                       // cycle 29
      drive_load(16'h2222, 4'h0, 1'b0);
      @(negedge clk);                       // cycle 30
      bus_if.load = 1'b0;
      @(negedge clk);                       // cycle 31, commit cycle
      drive_load(16'h3333, 4'h0, 1'b0);
      @(negedge clk);                       // cycle 0
      bus_if.load = 1'b0;
      chk("coinc frame_done", {15'h0, bus_if.frame_done}, 16'h0001);
      chk("coinc upd_pending kept", {15'h0, bus_if.upd_pending}, 16'h0001);
      check_frame("frame2222", 16'h2222, 4'b0000, 4'b1111);
      wait_frame_done("second commit");
      chk("second commit upd_pending", {15'h0, bus_if.upd_pending}, 16'h0000);
      check_frame("frame3333", 16'h3333, 4'b0000, 4'b1111);

      // Disable during digit-2 SHOW with data pending
      repeat (4) @(negedge clk);            // cycle 0
      drive_load(16'h5678, 4'b0001, 1'b0);
      @(negedge clk);                       // cycle 1
      bus_if.load = 1'b0;
      repeat (19) @(negedge clk);           // cycle 20
      chk("pre-dis an_n", {12'h0, bus_if.an_n}, 16'h000B);
      chk("pre-dis upd_pending", {15'h0, bus_if.upd_pending}, 16'h0001);
      bus_if.en = 1'b0;
      @(negedge clk);
      chk("dis an_n", {12'h0, bus_if.an_n}, 16'h000F);
      chk("dis seg_blank", {15'h0, bus_if.seg_blank}, 16'h0001);
      chk("dis upd_pending", {15'h0, bus_if.upd_pending}, 16'h0000);
      chk("dis frame_done", {15'h0, bus_if.frame_done}, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("dis hold an_n %0d", i), {12'h0, bus_if.an_n}, 16'h000F);
         chk($sformatf("dis hold frame_done %0d", i), {15'h0, bus_if.frame_done}, 16'h0000);
      end
      bus_if.en = 1'b1;                     // this falling edge is cycle 0 of the restart
      chk("restart an_n", {12'h0, bus_if.an_n}, 16'h000F);
      check_frame("restart", 16'h5678, 4'b0000, 4'b1110);

      // Asynchronous reset mid-SHOW of digit 3, with staged data that must be lost
      drive_load(16'h9999, 4'hF, 1'b1);
      @(negedge clk);                       // cycle 29
      bus_if.load = 1'b0;
      chk("pre-rst upd_pending", {15'h0, bus_if.upd_pending}, 16'h0001);
      chk("pre-rst an_n", {12'h0, bus_if.an_n}, 16'h0007);
      #2 rst = 1'b1;
      #1;
      chk("async an_n", {12'h0, bus_if.an_n}, 16'h000F);
      chk("async bcd", {12'h0, bus_if.bcd}, 16'h0000);
      chk("async seg_blank", {15'h0, bus_if.seg_blank}, 16'h0001);
      chk("async dp_n", {15'h0, bus_if.dp_n}, 16'h0001);
      chk("async upd_pending", {15'h0, bus_if.upd_pending}, 16'h0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;                           // cycle 0 of the resumed scan
      chk("post-rst an_n", {12'h0, bus_if.an_n}, 16'h000F);
      check_frame("post-rst", 16'h0000, 4'b0000, 4'b1111);
      chk("post-rst upd_pending", {15'h0, bus_if.upd_pending}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
